frame_painter: RTL and testbench

FRAME_PAINTER -- requirements
Module: frame_painter

---
 rtl/frame_painter.sv | 170 +++++++++++++++++
 tb/tb_frame_painter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_painter.sv
// Touch-panel frame painter: blanks a 1-bit frame buffer on request and paints a
// square brush around each accepted touch point, clipping at the frame edges.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting; accepts a clear request or a touch point
// S_CLEAR | writes 0 to every frame address, one per enabled cycle
// S_PAINT | walks the brush (dy outer, dx inner) writing 1 to in-frame pixels
module frame_painter #(
    parameter int BRUSH_SIZE = 5,
    parameter int COL_NUM    = 320,
    parameter int ROW_NUM    = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clear,
    input  logic        point_valid,
    input  logic [8:0]  point_x,
    input  logic [7:0]  point_y,
    output logic        point_ready,
    output logic        busy,
    output logic [16:0] write_addr,
    output logic        write_data,
    output logic        write_en
);

    localparam int                R         = (BRUSH_SIZE - 1) / 2;
    localparam logic [16:0]       LAST_ADDR = 17'(COL_NUM * ROW_NUM - 1);
    localparam logic [3:0]        BR_LAST   = 4'(BRUSH_SIZE - 1);
    localparam logic signed [10:0] R_S      = 11'(R);
    localparam logic signed [10:0] COL_S    = 11'(COL_NUM);
    localparam logic signed [10:0] ROW_S    = 11'(ROW_NUM);
    localparam logic [16:0]       COL_W     = 17'(COL_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_PAINT
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] clr_cnt_q, clr_cnt_d;
    logic [8:0]  cx_q, cx_d;
    logic [7:0]  cy_q, cy_d;
    logic [3:0]  dx_q, dx_d;
    logic [3:0]  dy_q, dy_d;
    logic        clear_pending_q, clear_pending_d;

    logic signed [10:0] px, py;
    logic [16:0]        px_u, py_u;
    logic               pix_ok;
    logic               brush_done;
    logic [16:0]        paint_addr;

    // Signed arithmetic so pixels left of / above the frame come out negative and clip.
    assign px = $signed({2'b00, cx_q}) + $signed({7'b0, dx_q}) - R_S;
    assign py = $signed({3'b000, cy_q}) + $signed({7'b0, dy_q}) - R_S;

    assign pix_ok = !px[10] && (px < COL_S) && !py[10] && (py < ROW_S);

    assign px_u       = {6'b0, px};
    assign py_u       = {6'b0, py};
    assign paint_addr = py_u * COL_W + px_u;

    assign brush_done = (dx_q == BR_LAST) && (dy_q == BR_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            clr_cnt_q       <= '0;
            cx_q            <= '0;
            cy_q            <= '0;
            dx_q            <= '0;
            dy_q            <= '0;
            clear_pending_q <= 1'b0;
        end else if (en) begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            cx_q            <= cx_d;
            cy_q            <= cy_d;
            dx_q            <= dx_d;
            dy_q            <= dy_d;
            clear_pending_q <= clear_pending_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        cx_d            = cx_q;
        cy_d            = cy_q;
        dx_d            = dx_q;
        dy_d            = dy_q;
        clear_pending_d = clear_pending_q;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else if (point_valid) begin
                    cx_d    = point_x;
                    cy_d    = point_y;
                    dx_d    = '0;
                    dy_d    = '0;
                    state_d = S_PAINT;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 17'd1;
                end
            end
            S_PAINT: begin
                if (clear) begin
                    clear_pending_d = 1'b1;
                end
                if (brush_done) begin
                    dx_d            = '0;
                    dy_d            = '0;
                    clear_pending_d = 1'b0;
                    // A clear arriving on the final brush cycle still counts.
                    if (clear_pending_q || clear) begin
                        state_d   = S_CLEAR;
                        clr_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (dx_q == BR_LAST) begin
                    dx_d = '0;
                    dy_d = dy_q + 4'd1;
                end else begin
                    dx_d = dx_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        point_ready = (state_q == S_IDLE) && en && !clear && !clear_pending_q;
        busy        = (state_q != S_IDLE);
        write_en    = 1'b0;
        write_addr  = '0;
        write_data  = 1'b0;

        case (state_q)
            S_CLEAR: begin
                write_en   = en;
                write_addr = clr_cnt_q;
                write_data = 1'b0;
            end
            S_PAINT: begin
                write_en   = en && pix_ok;
                write_addr = paint_addr;
                write_data = 1'b1;
            end
            default: begin
                write_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: reset, brush painting with clipping,
// clear sequencing, enable stalls and reset abort.
module tb_frame_painter;

    localparam int BS   = 5;
    localparam int COLS = 320;
    localparam int ROWS = 240;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        point_valid = 1'b0;
    logic [8:0]  point_x = '0;
    logic [7:0]  point_y = '0;
    logic        point_ready;
    logic        busy;
    logic [16:0] write_addr;
    logic        write_data;
    logic        write_en;

    int n_cmp = 0;
    int n_err = 0;

    int nw, nbad, first_a, last_a, nbusy, exp_a;

    frame_painter #(
        .BRUSH_SIZE(BS),
        .COL_NUM   (COLS),
        .ROW_NUM   (ROWS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .clear      (clear),
        .point_valid(point_valid),
        .point_x    (point_x),
        .point_y    (point_y),
        .point_ready(point_ready),
        .busy       (busy),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers a point, then samples exactly BS*BS brush cycles against the expected pixel walk.
    task automatic run_paint(input int x, input int y, input int clear_at,
                             output int o_nw, output int o_bad, output int o_first,
                             output int o_last, output int o_busy);
        int  px, py;
        logic inr;
        o_nw = 0; o_bad = 0; o_first = -1; o_last = -1; o_busy = 0;
        point_x     = 9'(x);
        point_y     = 8'(y);
        point_valid = 1'b1;
        #2;
        chk("accept_ready", 32'(point_ready), 32'd1);
        cyc();
        point_valid = 1'b0;
        for (int i = 0; i < BS * BS; i++) begin
            clear = (i == clear_at);
            #2;
            px  = x + (i % BS) - (BS - 1) / 2;
            py  = y + (i / BS) - (BS - 1) / 2;
            inr = (px >= 0) && (px < COLS) && (py >= 0) && (py < ROWS);
            if (busy === 1'b1) o_busy++;
            if (write_en !== inr) begin
                o_bad++;
            end else if (inr) begin
                o_nw++;
                if (o_first < 0) o_first = py * COLS + px;
                o_last = py * COLS + px;
                if (write_addr !== 17'(py * COLS + px) || write_data !== 1'b1) o_bad++;
            end
            cyc();
        end
        clear = 1'b0;
    endtask

    initial begin
        // reset state
        #1 reset_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_addr", 32'(write_addr), 32'd0);
        chk("rst_data", 32'(write_data), 32'd0);
        chk("rst_ready_en0", 32'(point_ready), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;

        // en low in IDLE: no acceptance, no state change
        cyc();
        point_valid = 1'b1;
        point_x     = 9'd10;
        point_y     = 8'd10;
        #2;
        chk("ready_en0", 32'(point_ready), 32'd0);
        cyc();
        point_valid = 1'b0;
        #2;
        chk("idle_en0_busy", 32'(busy), 32'd0);

        // normal paint at (100,50)
        cyc();
        en = 1'b1;
        run_paint(100, 50, -1, nw, nbad, first_a, last_a, nbusy);
        #2;
        chk("p1_idle_after", 32'(busy), 32'd0);
        chk("p1_writes", 32'(nw), 32'd25);
        chk("p1_bad", 32'(nbad), 32'd0);
        chk("p1_first", 32'(first_a), 32'd15458);
        chk("p1_last", 32'(last_a), 32'd16742);
        chk("p1_busy", 32'(nbusy), 32'd25);

        // top-left corner clipping
        cyc();
        run_paint(0, 0, -1, nw, nbad, first_a, last_a, nbusy);
        #2;
        chk("p0_idle_after", 32'(busy), 32'd0);
        chk("p0_writes", 32'(nw), 32'd9);
        chk("p0_bad", 32'(nbad), 32'd0);
        chk("p0_first", 32'(first_a), 32'd0);
        chk("p0_last", 32'(last_a), 32'd642);
        chk("p0_busy", 32'(nbusy), 32'd25);

        // bottom-right corner clipping
        cyc();
        run_paint(319, 239, -1, nw, nbad, first_a, last_a, nbusy);
        #2;
        chk("pbr_writes", 32'(nw), 32'd9);
        chk("pbr_bad", 32'(nbad), 32'd0);
        chk("pbr_first", 32'(first_a), 32'd76157);
        chk("pbr_last", 32'(last_a), 32'd76799);

        // point entirely outside the frame: no writes, still 25 cycles
        cyc();
        run_paint(330, 245, -1, nw, nbad, first_a, last_a, nbusy);
        #2;
        chk("pout_writes", 32'(nw), 32'd0);
        chk("pout_bad", 32'(nbad), 32'd0);
        chk("pout_busy", 32'(nbusy), 32'd25);
        chk("pout_idle_after", 32'(busy), 32'd0);

        // clear during PAINT: full brush, then CLEAR from address 0
        cyc();
        run_paint(200, 100, 3, nw, nbad, first_a, last_a, nbusy);
        #2;
        chk("cp_writes", 32'(nw), 32'd25);
        chk("cp_bad", 32'(nbad), 32'd0);
        chk("cp_busy", 32'(nbusy), 32'd25);
        chk("cp_clear_busy", 32'(busy), 32'd1);
        chk("cp_clear_we", 32'(write_en), 32'd1);
        chk("cp_clear_data", 32'(write_data), 32'd0);
        chk("cp_clear_addr0", 32'(write_addr), 32'd0);
        cyc();
        #2;
        chk("cp_clear_addr1", 32'(write_addr), 32'd1);

        // reset abandons CLEAR
        cyc();
        reset_n = 1'b0;
        #1;
        chk("clr_rst_we", 32'(write_en), 32'd0);
        chk("clr_rst_busy", 32'(busy), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        #2;
        chk("clr_rst_idle", 32'(busy), 32'd0);

        // reset mid-PAINT
        cyc();
        point_x     = 9'd100;
        point_y     = 8'd50;
        point_valid = 1'b1;
        cyc();
        point_valid = 1'b0;
        repeat (5) cyc();
        #2;
        chk("mp_busy", 32'(busy), 32'd1);
        chk("mp_we", 32'(write_en), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mp_rst_we", 32'(write_en), 32'd0);
        chk("mp_rst_busy", 32'(busy), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #2;
            if (write_en !== 1'b0 || busy !== 1'b0) nbad++;
        end
        chk("mp_post_quiet", 32'(nbad), 32'd0);
        chk("mp_post_ready", 32'(point_ready), 32'd1);

        // clear and point_valid together: clear wins; full sweep with en stall and ignored re-clear
        cyc();
        clear       = 1'b1;
        point_valid = 1'b1;
        point_x     = 9'd5;
        point_y     = 8'd5;
        #2;
        chk("cv_ready", 32'(point_ready), 32'd0);
        cyc();
        clear       = 1'b0;
        point_valid = 1'b0;
        nw = 0; nbad = 0; last_a = -1; exp_a = 0;
        for (int i = 0; i < 76810; i++) begin
            en    = !(i >= 30000 && i < 30010);
            clear = (i == 50000);
            #2;
            if (busy !== 1'b1) nbad++;
            if (en) begin
                if (write_en !== 1'b1 || write_data !== 1'b0 || write_addr !== 17'(exp_a)) begin
                    nbad++;
                end else begin
                    nw++;
                    last_a = 32'(write_addr);
                end
                exp_a++;
            end else begin
                if (write_en !== 1'b0 || write_addr !== 17'(exp_a)) nbad++;
            end
            cyc();
        end
        clear = 1'b0;
        en    = 1'b1;
        #2;
        chk("clr_writes", 32'(nw), 32'd76800);
        chk("clr_bad", 32'(nbad), 32'd0);
        chk("clr_last", 32'(last_a), 32'd76799);
        chk("clr_idle_busy", 32'(busy), 32'd0);
        chk("clr_idle_we", 32'(write_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
